// File: rtl/mkgauss_seq.sv
// mkgauss_seq: sequencer feeding PRNG word pairs to MKGAUSS and storing its samples
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   i_start, i_logn, i_abort   run control (i_logn sampled with an accepted i_start)
//   o_busy, o_done             run in progress, one-cycle completion pulse
//   i_rnd_valid, i_rnd         PRNG word stream, consumed when o_rnd_ready is high
//   o_r1_valid/o_r1,
//   o_r2_valid/o_r2            random word pair handed to MKGAUSS, one pulse each
//   i_val_valid, i_val         signed sample returned by MKGAUSS
//   o_wr_en, o_wr_addr,
//   o_wr_data                  coefficient buffer write port
module mkgauss_seq #(
   parameter int LOGN_MAX = 10,
   parameter int ADDR_W   = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_start,
   input  logic [3:0]        i_logn,
   input  logic              i_abort,
   output logic              o_busy,
   output logic              o_done,
   input  logic              i_rnd_valid,
   input  logic [63:0]       i_rnd,
   output logic              o_rnd_ready,
   output logic              o_r1_valid,
   output logic [63:0]       o_r1,
   output logic              o_r2_valid,
   output logic [63:0]       o_r2,
   input  logic              i_val_valid,
   input  logic [31:0]       i_val,
   output logic              o_wr_en,
   output logic [ADDR_W-1:0] o_wr_addr,
   output logic [31:0]       o_wr_data
);
   localparam int         CW     = LOGN_MAX + 1;
   localparam logic [3:0] LMAX   = 4'(LOGN_MAX);
   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] FETCH1 = 3'd1;
   localparam logic [2:0] FETCH2 = 3'd2;
   localparam logic [2:0] WAIT   = 3'd3;
   localparam logic [2:0] DONE   = 3'd4;
   localparam logic [2:0] FLUSH  = 3'd5;

   logic [2:0]        r_state, w_nxt;
   logic              r_busy, r_done, r_rnd_ready, r_r1_valid, r_r2_valid, r_wr_en;
   logic [63:0]       r_r1, r_r2;
   logic [ADDR_W-1:0] r_wr_addr;
   logic [31:0]       r_wr_data;
   logic [CW-1:0]     r_cnt, r_n;
   logic              w_go, w_hs, w_last, w_wr;
   logic [3:0]        w_logn;

   // r_busy still covers the done cycle, so a start there is treated as "while busy"
   assign w_go   = (r_state == IDLE) && !r_busy && i_start;
   // a word taken in an abort cycle is dropped: no pulse and no state advance
   assign w_hs   = r_rnd_ready && i_rnd_valid && !i_abort;
   assign w_last = r_cnt == r_n - CW'(1);
   assign w_wr   = (r_state == WAIT) && i_val_valid && !i_abort;
   assign w_logn = (i_logn > LMAX) ? LMAX : i_logn;

   always_comb begin
      w_nxt = r_state;
      case (r_state)
         IDLE:    w_nxt = w_go ? FETCH1 : IDLE;
         FETCH1:  w_nxt = i_abort ? IDLE : w_hs ? FETCH2 : FETCH1;
         FETCH2:  w_nxt = i_abort ? IDLE : w_hs ? WAIT : FETCH2;
         // an aborted sample still in flight must be drained, unless it arrives right now
         WAIT:    w_nxt = i_abort ? (i_val_valid ? IDLE : FLUSH)
                        : !i_val_valid ? WAIT : w_last ? DONE : FETCH1;
         DONE:    w_nxt = IDLE;
         FLUSH:   w_nxt = i_val_valid ? IDLE : FLUSH;
         default: w_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_rnd_ready <= 1'b0;
         r_r1_valid  <= 1'b0;
         r_r2_valid  <= 1'b0;
         r_r1        <= '0;
         r_r2        <= '0;
         r_wr_en     <= 1'b0;
         r_wr_addr   <= '0;
         r_wr_data   <= '0;
         r_cnt       <= '0;
         r_n         <= '0;
      end else begin
         r_state     <= w_nxt;
         // the done pulse is issued from the IDLE cycle following DONE, keep busy through it
         r_busy      <= (w_nxt != IDLE) || ((r_state == DONE) && !i_abort);
         r_done      <= (r_state == DONE) && !i_abort;
         r_rnd_ready <= (w_nxt == FETCH1) || (w_nxt == FETCH2);
         r_r1_valid  <= w_hs && (r_state == FETCH1);
         r_r2_valid  <= w_hs && (r_state == FETCH2);
         r_wr_en     <= w_wr;
         if (w_hs && (r_state == FETCH1)) r_r1 <= i_rnd;
         if (w_hs && (r_state == FETCH2)) r_r2 <= i_rnd;
         if (w_go) begin
            r_n   <= CW'(1) << w_logn;
            r_cnt <= '0;
         end
         if (w_wr) begin
            r_wr_addr <= ADDR_W'(r_cnt);
            r_wr_data <= i_val;
            r_cnt     <= r_cnt + CW'(1);
         end
      end
   end

   assign o_busy      = r_busy;
   assign o_done      = r_done;
   assign o_rnd_ready = r_rnd_ready;
   assign o_r1_valid  = r_r1_valid;
   assign o_r1        = r_r1;
   assign o_r2_valid  = r_r2_valid;
   assign o_r2        = r_r2;
   assign o_wr_en     = r_wr_en;
   assign o_wr_addr   = r_wr_addr;
   assign o_wr_data   = r_wr_data;
endmodule

// File: doc/mkgauss_seq.md
# mkgauss_seq

Sequencer for the MKGAUSS discrete Gaussian sampler. On a start command it pulls 64-bit random words from the PRNG stream and hands them to MKGAUSS as an r1/r2 pair per sample. It collects each signed sample and writes it to the coefficient buffer at consecutive addresses, until 2^logn samples are stored. It sits between the SHAKE-based PRNG and the key-generation polynomial memory.

## Interface
- LOGN_MAX, 10, largest supported log2 of sample count
- ADDR_W, 10, coefficient buffer address width (≥ LOGN_MAX)
- clk  in  1  system clock, all logic rising-edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle run request, accepted only in IDLE
- logn  in  4  log2 sample count, sampled with start; 0 → 1 sample; values > LOGN_MAX treated as LOGN_MAX
- abort  in  1  terminate current run
- busy  out  1  high from accepted start until return to IDLE
- done  out  1  one-cycle pulse after the last buffer write
- rnd_valid  in  1  PRNG word valid
- rnd  in  64  PRNG word
- rnd_ready  out  1  word consumed when rnd_valid && rnd_ready
- r1_valid  out  1  one-cycle pulse, r1 valid to MKGAUSS
- r1  out  64  first random word
- r2_valid  out  1  one-cycle pulse, r2 valid to MKGAUSS
- r2  out  64  second random word
- val_valid  in  1  MKGAUSS sample valid, one-cycle pulse
- val  in  32  signed sample
- wr_en  out  1  buffer write strobe
- wr_addr  out  ADDR_W  buffer address
- wr_data  out  32  sample written

## Operation
- States: IDLE, FETCH1, FETCH2, WAIT, DONE, FLUSH.
- IDLE: start → latch N = 2^min(logn, LOGN_MAX), clear cnt, go FETCH1.
- FETCH1: rnd_ready=1. On handshake: r1←rnd, r1_valid=1 for the following cycle, go FETCH2.
- FETCH2: rnd_ready=1. On handshake: r2←rnd, r2_valid=1 for the following cycle, go WAIT.
- WAIT: rnd_ready=0. On val_valid: wr_en=1, wr_addr=cnt, wr_data=val for the following cycle, cnt++. If cnt was N−1, go DONE; else go FETCH1.
- DONE: done=1 for one cycle, then IDLE.
- One sample outstanding at a time. Word order is strictly r1 then r2. No PRNG word is consumed outside FETCH1/FETCH2.
- val_valid outside WAIT/FLUSH is ignored.
- start while busy is ignored.
- abort in FETCH1/FETCH2/DONE: IDLE next cycle, no done, no further writes. A word handshaken in the abort cycle is discarded, with no r1/r2 pulse.
- abort in WAIT, or after r2 was issued: go FLUSH. FLUSH stays busy with wr_en=0 until val_valid, then IDLE. This prevents a stale sample entering the next run.
- abort and val_valid in the same WAIT cycle: sample is discarded, go IDLE directly.
- cnt is LOGN_MAX+1 bits wide, so N = 2^LOGN_MAX does not wrap. wr_addr = cnt[ADDR_W−1:0].

## Timing
- Reset values: busy=0, done=0, rnd_ready=0, r1_valid=0, r2_valid=0, r1=0, r2=0, wr_en=0, wr_addr=0, wr_data=0. State is IDLE, cnt=0.
- All outputs are registered. rnd_ready is driven from the state register.
- Start to first rnd_ready: 1 cycle. Handshake to r1_valid/r2_valid: 1 cycle.
- val_valid to wr_en: 1 cycle. Last wr_en to done: 1 cycle.
- Minimum cycles per sample: 2 fetch cycles + MKGAUSS latency + 1.
- With rnd_valid held high, consecutive handshakes in FETCH1 and FETCH2 occur on back-to-back cycles.
- busy falls in the cycle after done. In the done cycle, busy is still 1.
- Reset mid-run returns to IDLE immediately. All outputs go to their reset values asynchronously.

## Test plan
- logn=2, PRNG always valid with words 1,2,…,8, MKGAUSS model returns r1[31:0]−r2[31:0] → r1/r2 pairs (1,2),(3,4),(5,6),(7,8). Writes: addr 0..3, data −1 each. One done pulse, then busy=0.
- logn=0 → exactly one sample and one write at addr 0, done, 2 words consumed.
- PRNG with random rnd_valid gaps → r1/r2 order preserved, no word lost or duplicated, r1_valid never in the same cycle as r2_valid.
- abort one cycle after the r2_valid pulse, then start logn=1 immediately → first val_valid is discarded in FLUSH. Start is ignored while busy. A start after idle produces 2 writes at addr 0,1.
- val_valid injected in IDLE and FETCH1 → no wr_en. start while busy → N unchanged.
- logn=15 with LOGN_MAX=10 → 1024 writes, addr 0..1023, no wrap. rst_n low mid-run → all outputs 0 in the same cycle.
